// File: rtl/delay_align_ctrl.sv
// Calibration sequencer: sweeps the four delay_change settings, scores each by the sum of
// |ref_sig - dly_sig| over 2^LOG2_N enabled samples, and locks onto the lowest-error setting.
module delay_align_ctrl #(
    parameter int LOG2_N = 4,
    parameter int SETTLE = 4
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     sam_clk_en,
    input  logic                     start,
    input  logic signed [17:0]       ref_sig,
    input  logic signed [17:0]       dly_sig,
    output logic [1:0]               delay_change,
    output logic                     busy,
    output logic                     done,
    output logic [18+LOG2_N-1:0]     best_metric,
    output logic [2:0]               o_dbg_state
);

    localparam int ACC_W = 18 + LOG2_N;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_ACCUM   = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              r_state;
    logic [1:0]          r_d;
    logic [1:0]          r_best_idx;
    logic [3:0]          r_settle_cnt;
    logic [LOG2_N-1:0]   r_acc_cnt;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    r_best;

    logic signed [18:0]  w_diff;
    logic signed [18:0]  w_neg;
    logic [17:0]         w_abs;
    logic                w_better;
    logic                w_settle_last;
    logic                w_acc_last;

    // 19-bit difference cannot overflow; its magnitude always fits in 18 bits (max 262143).
    assign w_diff        = {ref_sig[17], ref_sig} - {dly_sig[17], dly_sig};
    assign w_neg         = -w_diff;
    assign w_abs         = w_diff[18] ? w_neg[17:0] : w_diff[17:0];
    assign w_better      = (r_acc < r_best);
    assign w_settle_last = (r_settle_cnt == 4'(SETTLE - 1));
    assign w_acc_last    = &r_acc_cnt;
    assign o_dbg_state   = r_state;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_d          <= 2'd0;
            r_best_idx   <= 2'd0;
            r_settle_cnt <= 4'd0;
            r_acc_cnt    <= '0;
            r_acc        <= '0;
            r_best       <= '0;
            delay_change <= 2'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            best_metric  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_SETTLE;
                        r_d          <= 2'd0;
                        delay_change <= 2'd0;
                        r_settle_cnt <= 4'd0;
                        r_acc_cnt    <= '0;
                        r_acc        <= '0;
                        r_best       <= '1;
                        r_best_idx   <= 2'd0;
                        busy         <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (sam_clk_en) begin
                        r_settle_cnt <= r_settle_cnt + 4'd1;
                        if (w_settle_last) begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (sam_clk_en) begin
                        r_acc     <= r_acc + ACC_W'(w_abs);
                        r_acc_cnt <= r_acc_cnt + 1'b1;
                        if (w_acc_last) begin
                            r_state <= S_COMPARE;
                        end
                    end
                end
                S_COMPARE: begin
                    // Strict compare: on a tie the earlier (smaller) delay wins.
                    if (w_better) begin
                        r_best     <= r_acc;
                        r_best_idx <= r_d;
                    end
                    if (r_d != 2'd3) begin
                        r_d          <= r_d + 2'd1;
                        delay_change <= r_d + 2'd1;
                        r_acc        <= '0;
                        r_acc_cnt    <= '0;
                        r_settle_cnt <= 4'd0;
                        r_state      <= S_SETTLE;
                    end else begin
                        // Commit on entry to DONE so results are valid while done is high.
                        delay_change <= w_better ? r_d : r_best_idx;
                        best_metric  <= w_better ? r_acc : r_best;
                        done         <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_align_ctrl.sv
// Directed bench for delay_align_ctrl: ramp alignment for each true delay, tie, full scale,
// ignored restart, async abort and enable gaps, each with hand-derived result and timing.
module tb_delay_align_ctrl;

    logic               sys_clk;
    logic               reset;
    logic               sam_clk_en;
    logic               start;
    logic signed [17:0] ref_sig;
    logic signed [17:0] dly_sig;
    logic [1:0]         delay_change;
    logic               busy;
    logic               done;
    logic [21:0]        best_metric;
    logic [2:0]         o_dbg_state;

    int n_vec;
    int n_err;

    logic signed [17:0] x_hist [0:511];
    int                 n_idx;
    int                 cur_mode;
    int                 cur_k;

    delay_align_ctrl #(.LOG2_N(4), .SETTLE(4)) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .sam_clk_en   (sam_clk_en),
        .start        (start),
        .ref_sig      (ref_sig),
        .dly_sig      (dly_sig),
        .delay_change (delay_change),
        .busy         (busy),
        .done         (done),
        .best_metric  (best_metric),
        .o_dbg_state  (o_dbg_state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Source x[n]; reference path lags by cur_k, delay stage lags by delay_change.
    task automatic tick(input bit en);
        sam_clk_en = en;
        case (cur_mode)
            0: begin
                ref_sig = x_hist[n_idx - cur_k];
                dly_sig = x_hist[n_idx - int'(delay_change)];
            end
            1: begin
                ref_sig = 18'sd1000;
                dly_sig = 18'sd1000;
            end
            default: begin
                ref_sig = 18'sd131071;
                dly_sig = -18'sd131072;
            end
        endcase
        @(posedge sys_clk);
        #1;
        if (en) n_idx++;
    endtask

    task automatic sweep(input int mode, input int k, input int restart_at, input int gap_at,
                         input int gap_len, input int abort_at,
                         output int done_edge, output int done_cnt, output int busy_fall);
        int p;
        int gap_left;
        bit en;
        cur_mode  = mode;
        cur_k     = k;
        n_idx     = 8;
        x_hist[0] = -18'sd20000;
        for (int i = 1; i < 512; i++)
            x_hist[i] = x_hist[i-1] + 18'($urandom_range(1, 200));
        done_edge = -1;
        done_cnt  = 0;
        busy_fall = -1;
        p         = 0;
        gap_left  = gap_len;
        start = 1'b1;
        tick(1'b0);
        start = 1'b0;
        for (int e = 1; e <= 2000; e++) begin
            if (gap_at >= 0 && p == gap_at && gap_left > 0) begin
                en = 1'b0;
                gap_left--;
            end else begin
                p++;
                en = (p % 4 == 0);
            end
            start = (e == restart_at);
            tick(en);
            start = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = e;
            end
            if (done_edge >= 0 && !busy && busy_fall < 0) busy_fall = e;
            if (e == abort_at) begin
                #2 reset = 1'b1;
                #1;
                check("abort_delay_change", 32'(delay_change), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_best_metric", 32'(best_metric), 32'd0);
                check("abort_state_idle", 32'(o_dbg_state), 32'd0);
                #2 reset = 1'b0;
            end
            if (abort_at < 0 && busy_fall >= 0 && e >= busy_fall + 3) break;
            if (abort_at >= 0 && e >= abort_at + 400) break;
        end
    endtask

    task automatic run_normal(input string tag, input int mode, input int k, input int restart_at,
                              input int gap_at, input int gap_len,
                              input int exp_dc, input int exp_metric, input int exp_edge);
        int de;
        int dc;
        int bf;
        sweep(mode, k, restart_at, gap_at, gap_len, -1, de, dc, bf);
        check({tag, "_done_edge"}, 32'(de), 32'(exp_edge));
        check({tag, "_done_count"}, 32'(dc), 32'd1);
        check({tag, "_busy_fall"}, 32'(bf), 32'(exp_edge + 1));
        check({tag, "_delay_change"}, 32'(delay_change), 32'(exp_dc));
        check({tag, "_best_metric"}, 32'(best_metric), 32'(exp_metric));
    endtask

    initial begin
        int de;
        int dc;
        int bf;
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        start      = 1'b0;
        sam_clk_en = 1'b0;
        ref_sig    = '0;
        dly_sig    = '0;
        cur_mode   = 1;
        cur_k      = 0;
        n_idx      = 8;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_delay_change", 32'(delay_change), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_best_metric", 32'(best_metric), 32'd0);
        check("rst_state", 32'(o_dbg_state), 32'd0);
        #4 reset = 1'b0;
        repeat (2) tick(1'b0);

        // Enable every 4th edge after start: each trial spans 80 edges, done seen at edge 321.
        for (int k = 0; k < 4; k++)
            run_normal($sformatf("align_k%0d", k), 0, k, -1, -1, 0, k, 0, 321);

        run_normal("tie", 1, 0, -1, -1, 0, 0, 0, 321);
        run_normal("full_scale", 2, 0, -1, -1, 0, 0, 4194288, 321);

        // Abort at edge 170, inside SETTLE of d=2 (which spans edges 161..176).
        sweep(0, 2, -1, -1, 0, 170, de, dc, bf);
        check("abort_no_done", 32'(dc), 32'd0);
        check("abort_idle_after", 32'(busy), 32'd0);
        run_normal("after_abort", 0, 2, -1, -1, 0, 2, 0, 321);

        // Edge 120 lies in ACCUM of d=1 (edges 96..160).
        run_normal("restart_ignored", 0, 1, 120, -1, 0, 1, 0, 321);

        // 50-cycle gap at edge 41 (ACCUM of d=0) shifts everything by 50.
        run_normal("enable_gap", 0, 3, -1, 41, 50, 3, 0, 371);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
